// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller:
// FSM state encodings, opcode constants, ALU control codes and alu_op codes.
package rv_ctrl_pkg;

    // Main FSM states (4-bit encoding)
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation selects
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Internal alu_op from the main FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Immediate format select derived from the opcode alone
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = 2'b01;
            OP_BEQ:  imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_multicycle_controller_if.sv
// Bundle of instruction fields in and control signals out of the controller.
// master = controller side, slave = datapath side.
interface rv_multicycle_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           imm_src;
    logic                 reg_write;
    logic [2:0]           alu_control;
    logic                 illegal_instr;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_control,
               illegal_instr, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_control,
               illegal_instr, instret
    );
endinterface

// File: rtl/rv_alu_decoder.sv
// Combinational ALU decoder: turns alu_op plus instruction fields into the
// 3-bit ALU operation select.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Select ALU operation; only R-type (op[5]=1) with funct7b5 means subtract
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        if (op5_i && funct7b5_i) begin
                            alu_control_o = ALU_SUB;
                        end else begin
                            alu_control_o = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_controller.sv
// Moore main control FSM of the multicycle RV32I core. Outputs are decoded
// combinationally from the state (plus instruction fields and zero) so they
// take effect in the same cycle the state is entered. Also counts retired
// instructions.
module rv_multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    rv_multicycle_controller_if.master ctrl
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    alu_op_t    alu_op_s;
    logic       pc_update_s;
    logic       branch_s;
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic       retire_s;
    logic [2:0] alu_control_s;

    // Next-state and per-state control decode
    always_comb begin
        state_d      = S_FETCH;
        alu_op_s     = ALUOP_ADD;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d      = S_DECODE;
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_update_s  = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm as a branch/jump target
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (ctrl.op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                state_d   = S_MEMWB;
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                state_d      = S_FETCH;
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                state_d     = S_FETCH;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                state_d     = S_ALUWB;
                alu_src_a_s = 2'b10;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                state_d     = S_ALUWB;
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                state_d     = S_FETCH;
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                // PC <- target computed in DECODE, ALU forms OldPC + 4 for rd
                state_d     = S_ALUWB;
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            S_BEQ: begin
                state_d     = S_FETCH;
                alu_src_a_s = 2'b10;
                alu_op_s    = ALUOP_SUB;
                branch_s    = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        pc_write_s = pc_update_s | (branch_s & ctrl.zero);
    end

    rv_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .funct3_i      (ctrl.funct3),
        .op5_i         (ctrl.op[5]),
        .funct7b5_i    (ctrl.funct7b5),
        .alu_control_o (alu_control_s)
    );

    // An instruction retires on the edge leaving its final state
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire_s = 1'b1;
            default:                             retire_s = 1'b0;
        endcase
        if (retire_s) begin
            instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign ctrl.pc_write      = pc_write_s;
    assign ctrl.adr_src       = adr_src_s;
    assign ctrl.mem_write     = mem_write_s;
    assign ctrl.ir_write      = ir_write_s;
    assign ctrl.result_src    = result_src_s;
    assign ctrl.alu_src_a     = alu_src_a_s;
    assign ctrl.alu_src_b     = alu_src_b_s;
    assign ctrl.imm_src       = imm_src_of(ctrl.op);
    assign ctrl.reg_write     = reg_write_s;
    assign ctrl.alu_control   = alu_control_s;
    assign ctrl.illegal_instr = illegal_s;
    assign ctrl.instret       = instret_q;

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Randomized self-checking bench for rv_multicycle_controller. The reference
// model describes each instruction class as a list of per-cycle control
// vectors and counts retirements in a plain integer.
module tb_rv_multicycle_controller;

    localparam int CW = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   retired;

    rv_multicycle_controller_if #(.CNT_WIDTH(CW)) bus ();

    rv_multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == JAL) || (op == BEQ);
    endfunction

    function automatic int instr_len(input logic [6:0] op);
        if (op == LW) return 5;
        if (op == BEQ) return 3;
        if (is_legal(op)) return 4;
        return 2;
    endfunction

    // ALU operation an R/I instruction asks for
    function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control vector for cycle 'step' of an instruction
    // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, imm_src, reg_write, alu_control, illegal}
    function automatic logic [16:0] exp_out(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7, input logic z, input int step);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
        if (step == 0) begin
            irw = 1'b1; pcw = 1'b1; b = 2'b10; rs = 2'b10;
        end else if (step == 1) begin
            a = 2'b01; b = 2'b01; ill = !is_legal(op);
        end else if (step == 2) begin
            if (op == LW || op == SW) begin a = 2'b10; b = 2'b01; end
            else if (op == RT) begin a = 2'b10; alu = alu_ref(op, f3, f7); end
            else if (op == IT) begin a = 2'b10; b = 2'b01; alu = alu_ref(op, f3, f7); end
            else if (op == JAL) begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            else if (op == BEQ) begin a = 2'b10; alu = 3'b001; pcw = z; end
        end else if (step == 3) begin
            if (op == LW) adr = 1'b1;
            else if (op == SW) begin adr = 1'b1; mw = 1'b1; end
            else rw = 1'b1;
        end else begin
            rs = 2'b01; rw = 1'b1;
        end
        return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.reg_write,
                bus.alu_control, bus.illegal_instr};
    endfunction

    // Run one instruction starting just after the edge that entered FETCH.
    // zsel: 0/1 force zero, 2 = random every cycle. abort_step >= 0 asserts
    // reset in the middle of that cycle instead of completing.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int zsel, input int abort_step);
        int n;
        n = instr_len(op);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        for (int step = 0; step < n; step++) begin
            bus.zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            @(negedge clk);
            check_eq($sformatf("ctl op=%b s%0d", op, step), 32'(observed()),
                     32'(exp_out(op, f3, f7, bus.zero, step)));
            if (step == 0) check_eq("instret", 32'(bus.instret), 32'(retired % (1 << CW)));
            if (step == abort_step) begin
                #1 reset = 1'b1;
                #1;
                retired = 0;
                check_eq("abort ctl", 32'(observed()), 32'(exp_out(op, f3, f7, bus.zero, 0)));
                check_eq("abort instret", 32'(bus.instret), 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (is_legal(op)) retired++;
    endtask

    task automatic run_random(input bit legal_only);
        logic [6:0] ops [6];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, JAL, BEQ};
        op = ops[$urandom_range(0, 5)];
        if (!legal_only && $urandom_range(0, 7) == 0) begin
            op = 7'($urandom);
            for (int k = 0; k < 20 && is_legal(op); k++) op = 7'($urandom);
            if (is_legal(op)) op = 7'b1111111;
        end
        run_instr(op, 3'($urandom), 1'($urandom), 2, -1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; retired = 0;
        reset = 1'b1;
        bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        // Reset state with reset held
        @(negedge clk);
        check_eq("reset ctl", 32'(observed()), 32'(exp_out(LW, 3'b010, 1'b0, 1'b0, 0)));
        check_eq("reset instret", 32'(bus.instret), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        run_instr(LW, 3'b010, 1'b0, 0, -1);
        run_instr(RT, 3'b000, 1'b1, 0, -1);     // sub
        run_instr(RT, 3'b000, 1'b0, 0, -1);     // add
        run_instr(IT, 3'b000, 1'b1, 0, -1);     // addi, not sub
        run_instr(RT, 3'b110, 1'b0, 0, -1);     // or
        run_instr(IT, 3'b111, 1'b0, 0, -1);     // andi
        run_instr(RT, 3'b010, 1'b0, 0, -1);     // slt
        run_instr(BEQ, 3'b000, 1'b0, 1, -1);    // taken
        run_instr(BEQ, 3'b000, 1'b0, 0, -1);    // not taken
        run_instr(SW, 3'b010, 1'b0, 2, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, -1);
        run_instr(JAL, 3'b000, 1'b0, 2, -1);

        // Random mix including illegal opcodes
        for (int i = 0; i < 40; i++) run_random(1'b0);

        // Reset during MEMWRITE
        run_instr(SW, 3'b010, 1'b0, 2, 3);

        // Fill counter to all-ones, then one jal wraps it to zero
        for (int i = 0; i < 15; i++) run_random(1'b1);
        run_instr(JAL, 3'b000, 1'b0, 2, -1);
        run_instr(LW, 3'b010, 1'b0, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
